// File: rtl/excp_ctrl.sv
// Exception/interrupt sequencer for CP0.
// Picks the highest-priority MEM-stage exception or pending interrupt, pulses
// the CP0 update strobes, holds a pipeline flush for FLUSH_CYCLES cycles and
// then issues a single PC redirect to the exception vector (or EPC for ERET).
module excp_ctrl #(
    parameter logic [31:0] EXC_VECTOR   = 32'h80000180,
    parameter int          FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        exc_valid,
    input  logic [31:0] exc_pc,
    input  logic        exc_in_delay,
    input  logic [31:0] exc_badvaddr,
    input  logic [7:0]  exc_flags,
    input  logic [5:0]  hw_irq,
    input  logic        cp0_status_ie,
    input  logic        cp0_status_exl,
    input  logic [7:0]  cp0_status_im,
    input  logic [1:0]  cp0_cause_ip_sw,
    input  logic [31:0] cp0_epc,
    output logic [5:0]  ip_hw,
    output logic        cp0_cause_we,
    output logic [4:0]  cp0_excode,
    output logic        cp0_bd,
    output logic        cp0_epc_we,
    output logic [31:0] cp0_epc_o,
    output logic        cp0_badvaddr_we,
    output logic [31:0] cp0_badvaddr_o,
    output logic        cp0_set_exl,
    output logic        cp0_clr_exl,
    output logic        flush,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FLUSH    = 2'd1,
        REDIRECT = 2'd2
    } state_t;

    // Counter reload: FLUSH is left when the counter reaches zero.
    localparam logic [3:0] FLUSH_LAST = 4'(FLUSH_CYCLES - 1);

    state_t      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic [5:0]  irq_sync_p0;
    logic        int_req;
    logic        sel_exc;
    logic        sel_eret;
    logic [4:0]  sel_code;
    logic        sel_badv_we;
    logic [31:0] sel_badv;
    logic        event_in;
    logic [31:0] tgt_p0;

    // Two-flop synchroniser for the asynchronous interrupt lines.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_sync_p0 <= '0;
            ip_hw       <= '0;
        end else begin
            irq_sync_p0 <= hw_irq;
            ip_hw       <= irq_sync_p0;
        end
    end

    assign int_req = cp0_status_ie & ~cp0_status_exl &
                     (|(cp0_status_im & {ip_hw, cp0_cause_ip_sw}));

    // Priority select: interrupt first, then the exception flags, ERET last.
    always_comb begin
        sel_exc     = 1'b0;
        sel_eret    = 1'b0;
        sel_code    = 5'd0;
        sel_badv_we = 1'b0;
        sel_badv    = exc_badvaddr;
        if (int_req) begin
            sel_exc  = 1'b1;
            sel_code = 5'd0;
        end else if (exc_flags[0]) begin
            sel_exc     = 1'b1;
            sel_code    = 5'd4;
            sel_badv_we = 1'b1;
            sel_badv    = exc_pc;
        end else if (exc_flags[1]) begin
            sel_exc  = 1'b1;
            sel_code = 5'd10;
        end else if (exc_flags[4]) begin
            sel_exc  = 1'b1;
            sel_code = 5'd12;
        end else if (exc_flags[2]) begin
            sel_exc  = 1'b1;
            sel_code = 5'd8;
        end else if (exc_flags[3]) begin
            sel_exc  = 1'b1;
            sel_code = 5'd9;
        end else if (exc_flags[5]) begin
            sel_exc     = 1'b1;
            sel_code    = 5'd4;
            sel_badv_we = 1'b1;
        end else if (exc_flags[6]) begin
            sel_exc     = 1'b1;
            sel_code    = 5'd5;
            sel_badv_we = 1'b1;
        end else if (exc_flags[7]) begin
            sel_eret = 1'b1;
        end
    end

    // An interrupt with no valid instruction in MEM stays pending here.
    assign event_in = exc_valid & (sel_exc | sel_eret);

    // State register and flush counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state logic; new events are only looked at in IDLE.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (event_in) begin
                    state_nxt = FLUSH;
                    cnt_nxt   = FLUSH_LAST;
                end
            end
            FLUSH: begin
                if (cnt == 4'd0) begin
                    state_nxt = REDIRECT;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            REDIRECT: state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // Sequence outputs decoded straight from the state register.
    always_comb begin
        flush          = (state != IDLE);
        redirect_valid = (state == REDIRECT);
        busy           = (state != IDLE);
    end

    // CP0 strobes pulse for one cycle after acceptance; data fields hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cp0_cause_we    <= 1'b0;
            cp0_excode      <= '0;
            cp0_bd          <= 1'b0;
            cp0_epc_we      <= 1'b0;
            cp0_epc_o       <= '0;
            cp0_badvaddr_we <= 1'b0;
            cp0_badvaddr_o  <= '0;
            cp0_set_exl     <= 1'b0;
            cp0_clr_exl     <= 1'b0;
            redirect_pc     <= '0;
        end else begin
            cp0_cause_we    <= 1'b0;
            cp0_epc_we      <= 1'b0;
            cp0_badvaddr_we <= 1'b0;
            cp0_set_exl     <= 1'b0;
            cp0_clr_exl     <= 1'b0;
            if (state == IDLE && event_in) begin
                cp0_cause_we    <= sel_exc;
                cp0_set_exl     <= sel_exc;
                cp0_epc_we      <= sel_exc & ~cp0_status_exl;
                cp0_badvaddr_we <= sel_badv_we;
                cp0_clr_exl     <= sel_eret;
                if (sel_exc) begin
                    cp0_excode <= sel_code;
                    cp0_bd     <= exc_in_delay;
                    cp0_epc_o  <= exc_in_delay ? (exc_pc - 32'd4) : exc_pc;
                end
                if (sel_badv_we) begin
                    cp0_badvaddr_o <= sel_badv;
                end
            end
            if (state == FLUSH && cnt == 4'd0) begin
                redirect_pc <= tgt_p0;
            end
        end
    end

    // Redirect target captured with the event (EPC is sampled at acceptance).
    always_ff @(posedge clk) begin
        if (state == IDLE && event_in) begin
            tgt_p0 <= sel_eret ? cp0_epc : EXC_VECTOR;
        end
    end

endmodule

// File: tb/tb_excp_ctrl.sv
// Directed bench for excp_ctrl: drives on the falling edge, samples on the
// falling edge, compares against hand-computed values.
module tb_excp_ctrl;

    logic        clk;
    logic        rst_n;
    logic        exc_valid;
    logic [31:0] exc_pc;
    logic        exc_in_delay;
    logic [31:0] exc_badvaddr;
    logic [7:0]  exc_flags;
    logic [5:0]  hw_irq;
    logic        cp0_status_ie;
    logic        cp0_status_exl;
    logic [7:0]  cp0_status_im;
    logic [1:0]  cp0_cause_ip_sw;
    logic [31:0] cp0_epc;
    logic [5:0]  ip_hw;
    logic        cp0_cause_we;
    logic [4:0]  cp0_excode;
    logic        cp0_bd;
    logic        cp0_epc_we;
    logic [31:0] cp0_epc_o;
    logic        cp0_badvaddr_we;
    logic [31:0] cp0_badvaddr_o;
    logic        cp0_set_exl;
    logic        cp0_clr_exl;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        busy;

    int n_chk  = 0;
    int n_pass = 0;

    logic [7:0] strb;
    assign strb = {busy, flush, redirect_valid, cp0_cause_we, cp0_epc_we,
                   cp0_badvaddr_we, cp0_set_exl, cp0_clr_exl};

    excp_ctrl #(
        .EXC_VECTOR   (32'h80000180),
        .FLUSH_CYCLES (2)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .exc_valid       (exc_valid),
        .exc_pc          (exc_pc),
        .exc_in_delay    (exc_in_delay),
        .exc_badvaddr    (exc_badvaddr),
        .exc_flags       (exc_flags),
        .hw_irq          (hw_irq),
        .cp0_status_ie   (cp0_status_ie),
        .cp0_status_exl  (cp0_status_exl),
        .cp0_status_im   (cp0_status_im),
        .cp0_cause_ip_sw (cp0_cause_ip_sw),
        .cp0_epc         (cp0_epc),
        .ip_hw           (ip_hw),
        .cp0_cause_we    (cp0_cause_we),
        .cp0_excode      (cp0_excode),
        .cp0_bd          (cp0_bd),
        .cp0_epc_we      (cp0_epc_we),
        .cp0_epc_o       (cp0_epc_o),
        .cp0_badvaddr_we (cp0_badvaddr_we),
        .cp0_badvaddr_o  (cp0_badvaddr_o),
        .cp0_set_exl     (cp0_set_exl),
        .cp0_clr_exl     (cp0_clr_exl),
        .flush           (flush),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .busy            (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Present one instruction for a single edge; returns at the negedge of cycle k+1.
    task automatic fire(input logic [7:0] flags, input logic [31:0] pc,
                        input logic dly, input logic [31:0] badv);
        exc_valid    = 1'b1;
        exc_flags    = flags;
        exc_pc       = pc;
        exc_in_delay = dly;
        exc_badvaddr = badv;
        @(posedge clk);
        @(negedge clk);
        exc_valid    = 1'b0;
        exc_flags    = 8'h00;
        exc_in_delay = 1'b0;
    endtask

    // From cycle k+1 to the first IDLE cycle k+4.
    task automatic finish_seq();
        repeat (3) step();
    endtask

    initial begin
        rst_n           = 1'b0;
        exc_valid       = 1'b0;
        exc_pc          = '0;
        exc_in_delay    = 1'b0;
        exc_badvaddr    = '0;
        exc_flags       = '0;
        hw_irq          = '0;
        cp0_status_ie   = 1'b0;
        cp0_status_exl  = 1'b0;
        cp0_status_im   = '0;
        cp0_cause_ip_sw = '0;
        cp0_epc         = '0;

        repeat (3) step();
        chk("rst_strb",   32'(strb), 32'h0);
        chk("rst_rpc",    redirect_pc, 32'h0);
        chk("rst_iphw",   32'(ip_hw), 32'h0);
        chk("rst_excode", 32'(cp0_excode), 32'h0);
        chk("rst_epco",   cp0_epc_o, 32'h0);
        rst_n = 1'b1;

        // Idle with flags toggling but no valid instruction.
        for (int i = 0; i < 10; i++) begin
            exc_flags = (i % 2 == 1) ? 8'hFF : 8'h5A;
            step();
            chk("idle_strb", 32'(strb), 32'h0);
        end
        exc_flags = 8'h00;
        step();

        // SYSCALL, not in delay slot.
        fire(8'h04, 32'h00400010, 1'b0, 32'h0);
        chk("sys_excode", 32'(cp0_excode), 32'd8);
        chk("sys_cwe",    32'(cp0_cause_we), 32'd1);
        chk("sys_epcwe",  32'(cp0_epc_we), 32'd1);
        chk("sys_epco",   cp0_epc_o, 32'h00400010);
        chk("sys_setexl", 32'(cp0_set_exl), 32'd1);
        chk("sys_bd",     32'(cp0_bd), 32'd0);
        chk("sys_bvwe",   32'(cp0_badvaddr_we), 32'd0);
        chk("sys_flush1", 32'(flush), 32'd1);
        chk("sys_rv1",    32'(redirect_valid), 32'd0);
        exc_valid = 1'b1;
        exc_flags = 8'h02;
        step();
        chk("sys_cwe2",   32'(cp0_cause_we), 32'd0);
        chk("sys_exl2",   32'(cp0_set_exl), 32'd0);
        chk("sys_flush2", 32'(flush), 32'd1);
        chk("sys_rv2",    32'(redirect_valid), 32'd0);
        exc_valid = 1'b0;
        exc_flags = 8'h00;
        step();
        chk("sys_rv3",    32'(redirect_valid), 32'd1);
        chk("sys_rpc3",   redirect_pc, 32'h80000180);
        chk("sys_flush3", 32'(flush), 32'd1);
        chk("sys_cwe3",   32'(cp0_cause_we), 32'd0);

        // Ov in a delay slot presented during REDIRECT: taken one edge later.
        exc_valid    = 1'b1;
        exc_flags    = 8'h10;
        exc_pc       = 32'h00400024;
        exc_in_delay = 1'b1;
        step();
        chk("b2b_rv4",    32'(redirect_valid), 32'd0);
        chk("b2b_flush4", 32'(flush), 32'd0);
        chk("b2b_cwe4",   32'(cp0_cause_we), 32'd0);
        chk("b2b_rpc4",   redirect_pc, 32'h80000180);
        step();
        exc_valid    = 1'b0;
        exc_flags    = 8'h00;
        exc_in_delay = 1'b0;
        chk("ov_cwe",     32'(cp0_cause_we), 32'd1);
        chk("ov_excode",  32'(cp0_excode), 32'd12);
        chk("ov_bd",      32'(cp0_bd), 32'd1);
        chk("ov_epco",    cp0_epc_o, 32'h00400020);
        finish_seq();
        chk("ov_idle",    32'(strb), 32'h0);

        // Delay slot at PC 0 wraps EPC.
        fire(8'h10, 32'h00000000, 1'b1, 32'h0);
        chk("wrap_epco",  cp0_epc_o, 32'hFFFFFFFC);
        finish_seq();

        // Fetch AdEL beats RI; BadVAddr comes from the PC.
        fire(8'h03, 32'h00400030, 1'b0, 32'h12345678);
        chk("fadel_excode", 32'(cp0_excode), 32'd4);
        chk("fadel_bvwe",   32'(cp0_badvaddr_we), 32'd1);
        chk("fadel_bvo",    cp0_badvaddr_o, 32'h00400030);
        finish_seq();

        // Data AdES.
        fire(8'h40, 32'h00400034, 1'b0, 32'h00000003);
        chk("ades_excode", 32'(cp0_excode), 32'd5);
        chk("ades_bvwe",   32'(cp0_badvaddr_we), 32'd1);
        chk("ades_bvo",    cp0_badvaddr_o, 32'h00000003);
        finish_seq();

        // BREAK beats data AdEL; no BadVAddr update.
        fire(8'h28, 32'h00400038, 1'b0, 32'h00000007);
        chk("brk_excode", 32'(cp0_excode), 32'd9);
        chk("brk_bvwe",   32'(cp0_badvaddr_we), 32'd0);
        chk("brk_bvo",    cp0_badvaddr_o, 32'h00000003);
        finish_seq();

        // Exception while EXL already set: no EPC write.
        cp0_status_exl = 1'b1;
        fire(8'h08, 32'h0040003C, 1'b0, 32'h0);
        chk("exl_epcwe",  32'(cp0_epc_we), 32'd0);
        chk("exl_cwe",    32'(cp0_cause_we), 32'd1);
        chk("exl_setexl", 32'(cp0_set_exl), 32'd1);
        finish_seq();
        cp0_status_exl = 1'b0;

        // Interrupt: synchroniser latency, pending without valid instr, beats SYSCALL.
        hw_irq        = 6'h01;
        cp0_status_im = 8'h04;
        cp0_status_ie = 1'b1;
        step();
        chk("irq_sync1", 32'(ip_hw), 32'h0);
        step();
        chk("irq_sync2", 32'(ip_hw), 32'h1);
        chk("irq_pend",  32'(busy), 32'd0);
        step();
        chk("irq_pend2", 32'(busy), 32'd0);
        fire(8'h04, 32'h00400050, 1'b0, 32'h0);
        chk("irq_excode", 32'(cp0_excode), 32'd0);
        chk("irq_cwe",    32'(cp0_cause_we), 32'd1);
        chk("irq_epco",   cp0_epc_o, 32'h00400050);
        finish_seq();
        chk("irq_rpc",    redirect_pc, 32'h80000180);

        // EXL masks the interrupt.
        cp0_status_exl = 1'b1;
        exc_valid      = 1'b1;
        exc_flags      = 8'h00;
        step();
        exc_valid = 1'b0;
        chk("irqexl_busy", 32'(busy), 32'd0);
        chk("irqexl_cwe",  32'(cp0_cause_we), 32'd0);
        fire(8'h04, 32'h00400060, 1'b0, 32'h0);
        chk("irqexl_excode", 32'(cp0_excode), 32'd8);
        finish_seq();
        hw_irq         = 6'h00;
        cp0_status_ie  = 1'b0;
        cp0_status_exl = 1'b0;
        cp0_status_im  = 8'h00;
        repeat (2) step();

        // ERET: only clr_exl pulses, target is EPC sampled at acceptance.
        cp0_epc = 32'h00400100;
        fire(8'h80, 32'h00400070, 1'b0, 32'h0);
        cp0_epc = 32'hDEADBEEF;
        chk("eret_clr",   32'(cp0_clr_exl), 32'd1);
        chk("eret_cwe",   32'(cp0_cause_we), 32'd0);
        chk("eret_set",   32'(cp0_set_exl), 32'd0);
        chk("eret_epcwe", 32'(cp0_epc_we), 32'd0);
        chk("eret_bvwe",  32'(cp0_badvaddr_we), 32'd0);
        chk("eret_flush", 32'(flush), 32'd1);
        step();
        chk("eret_clr2",  32'(cp0_clr_exl), 32'd0);
        step();
        chk("eret_rv",    32'(redirect_valid), 32'd1);
        chk("eret_rpc",   redirect_pc, 32'h00400100);
        step();

        // Reset during FLUSH aborts the sequence.
        fire(8'h04, 32'h00400080, 1'b0, 32'h0);
        chk("rstm_busy1", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rstm_busy0", 32'(busy), 32'd0);
        chk("rstm_strb",  32'(strb), 32'h0);
        chk("rstm_rpc",   redirect_pc, 32'h0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("rstm_norv", 32'(strb), 32'h0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/excp_ctrl.md
Name: excp_ctrl

Overview:
- Exception/interrupt sequencer for the CP0 block of the MIPS pipeline.
- Samples the MEM-stage exception flags and synchronised hardware interrupts, then selects the single highest-priority event.
- Drives CP0 update strobes (EPC, Cause, BadVAddr, Status.EXL), holds a pipeline flush for a fixed window, then issues one PC redirect to the exception vector or, for ERET, to EPC.

Parameters:
- EXC_VECTOR, 32'h80000180: redirect target for every exception and interrupt.
- FLUSH_CYCLES, 2: cycles spent in FLUSH before REDIRECT; legal range 1..15.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- exc_valid  in  1  MEM-stage instruction valid
- exc_pc  in  32  MEM-stage instruction PC
- exc_in_delay  in  1  instruction sits in a branch delay slot
- exc_badvaddr  in  32  faulting data address
- exc_flags  in  8  [0] fetch AdEL, [1] RI, [2] SYSCALL, [3] BREAK, [4] Ov, [5] data AdEL, [6] AdES, [7] ERET
- hw_irq  in  6  asynchronous hardware interrupt lines
- cp0_status_ie, cp0_status_exl  in  1 each  current Status bits
- cp0_status_im  in  8  Status.IM
- cp0_cause_ip_sw  in  2  Cause.IP[1:0]
- cp0_epc  in  32  current EPC
- ip_hw  out  6  synchronised interrupt lines, to Cause.IP[7:2]
- cp0_cause_we  out  1  Cause write strobe
- cp0_excode  out  5  ExcCode
- cp0_bd  out  1  Cause.BD
- cp0_epc_we  out  1  EPC write strobe
- cp0_epc_o  out  32  EPC write data
- cp0_badvaddr_we  out  1  BadVAddr write strobe
- cp0_badvaddr_o  out  32  BadVAddr write data
- cp0_set_exl, cp0_clr_exl  out  1 each  Status.EXL strobes
- flush  out  1  flush IF..MEM
- redirect_valid  out  1  PC redirect strobe
- redirect_pc  out  32  PC redirect target
- busy  out  1  state != IDLE

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE; synchroniser flops are cleared.
  - All outputs go to 0, including redirect_pc.
  - Reset mid-sequence aborts it; no redirect follows.
- Interrupt synchronisation: hw_irq passes through 2 flops, so ip_hw lags hw_irq by 2 edges.
- Interrupt request: int_req = ie & !exl & |(im & {ip_hw, cp0_cause_ip_sw}).
- Event selection (IDLE only): an event exists when exc_valid=1 and (int_req or |exc_flags). Priority, highest first, with ExcCode:
  - Int 0
  - fetch AdEL 4
  - RI 10
  - Ov 12
  - SYSCALL 8
  - BREAK 9
  - data AdEL 4
  - AdES 5
  - ERET (no code)
- Interrupt with exc_valid=0: the interrupt stays pending until a valid instruction reaches MEM.
- State IDLE: on an event at edge k, the block latches the event and moves to FLUSH. From cycle k+1, the following strobes are asserted for exactly one cycle:
  - Exception/interrupt:
    - cp0_cause_we=1, with cp0_excode and cp0_bd=exc_in_delay.
    - cp0_set_exl=1.
    - cp0_epc_we=!exl, with cp0_epc_o = exc_in_delay ? exc_pc-4 : exc_pc (32-bit wrap).
  - BadVAddr: cp0_badvaddr_we=1 only for AdEL/AdES; data is exc_pc for fetch AdEL, exc_badvaddr otherwise.
  - ERET: only cp0_clr_exl=1; target = cp0_epc sampled at edge k.
- State FLUSH: flush=1 for FLUSH_CYCLES cycles (4-bit counter), then the block moves to REDIRECT.
- State REDIRECT:
  - Asserts flush=1 and redirect_valid=1 for one cycle; redirect_pc = EXC_VECTOR or the sampled EPC.
  - Then returns to IDLE; flush and redirect_valid drop the next cycle.
- Events while busy: exc_flags and int_req are ignored. The flushed instruction re-presents later; a still-pending interrupt is retaken once back in IDLE.
- Back-to-back events: the earliest re-acceptance is the cycle after REDIRECT.
- Output hold: outputs are registered; redirect_pc holds its last value until the next REDIRECT.

Test Plan:
- Reset then idle: all outputs 0, busy=0 for 10 cycles, even with exc_flags toggling while exc_valid=0.
- SYSCALL: exc_pc=32'h00400010, exl=0, in_delay=0.
  - Required: next cycle cp0_excode=8, cp0_epc_we=1, cp0_epc_o=32'h00400010, cp0_set_exl=1, flush=1.
  - With FLUSH_CYCLES=2: redirect_valid=1, redirect_pc=32'h80000180 on cycle k+3.
- Delay-slot Ov: exc_pc=32'h00400024, in_delay=1 → cp0_excode=12, cp0_bd=1, cp0_epc_o=32'h00400020.
- Fetch AdEL with RI also set → cp0_excode=4, cp0_badvaddr_o=exc_pc. Data AdES with exc_badvaddr=32'h00000003 → cp0_excode=5, cp0_badvaddr_o=32'h00000003.
- Interrupt:
  - Setup: hw_irq[0] rises, im=8'h04, ie=1, exl=0, and SYSCALL is present at the same time.
  - Required: ip_hw[0]=1 two edges later; the event is taken as cp0_excode=0 (interrupt beats SYSCALL).
  - With exl=1: no interrupt is taken.
- ERET with cp0_epc=32'h00400100 → only cp0_clr_exl pulses, then redirect_pc=32'h00400100. Asserting rst_n=0 during FLUSH gives no redirect and busy=0 immediately.
